// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver.
package seg_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX    = 4'd9;
    localparam int   SEL_W      = 3;
    localparam int   MAX_DIGITS = 8;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} scan_state_t;

    function automatic logic bcd_bad(input bcd_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/seg_blank_calc.sv
// Per-digit blank flags: invalid codes always blank, leading zeros optionally blank.
module seg_blank_calc
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  bcd_t [DIGITS-1:0] disp,
    output logic [DIGITS-1:0] blank
);

    logic zeros;

    // Walk from the most significant digit down so 'zeros' means "this and all above are 0".
    always_comb begin
        blank = '0;
        zeros = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zeros    = zeros & (disp[i] == 4'd0);
            blank[i] = bcd_bad(disp[i]) | (LZ_BLANK && (i > 0) && zeros);
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Scan controller for a multiplexed 7-segment bank: slot timing, gap blanking,
// double-buffered display data and registered decoder-facing outputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned CLK_DIV  = 50000,
    parameter int unsigned GAP_CYC  = 4,
    parameter bit          LZ_BLANK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [SEL_W-1:0]      sel,
    output logic                  sel_en,
    output bcd_t                  bcd_out,
    output logic                  dp_out,
    output logic                  frame_tick,
    output logic                  err
);

    localparam int unsigned        CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   SHOW_LAST = CNT_W'(CLK_DIV - GAP_CYC - 1);
    localparam logic [CNT_W-1:0]   SLOT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [SEL_W-1:0]   IDX_LAST  = SEL_W'(DIGITS - 1);

    scan_state_t              state, state_n;
    logic [SEL_W-1:0]         idx, idx_n;
    logic [CNT_W-1:0]         div_cnt, cnt_n;
    logic                     wrap, tick;

    bcd_t [DIGITS-1:0]        in_dig;
    bcd_t [DIGITS-1:0]        pend, disp, disp_n;
    logic [DIGITS-1:0]        pend_dp, disp_dp, disp_dp_n;
    logic                     pend_vld;
    logic                     upd, err_n;
    logic [DIGITS-1:0]        blank_n;

    bcd_t                     cur_bcd;
    logic                     cur_dp, cur_blank;

    assign in_dig = bcd_in;

    // Slot sequencing
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = div_cnt;
        wrap    = 1'b0;
        tick    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n = SHOW;
                    idx_n   = '0;
                    cnt_n   = '0;
                    tick    = 1'b1;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = div_cnt + 1'b1;
                    if (div_cnt == SHOW_LAST) state_n = GAP;
                end
            end
            GAP: begin
                if (!en) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    cnt_n   = '0;
                end else if (div_cnt == SLOT_LAST) begin
                    state_n = SHOW;
                    cnt_n   = '0;
                    wrap    = (idx == IDX_LAST);
                    tick    = wrap;
                    idx_n   = wrap ? '0 : idx + 1'b1;
                end else begin
                    cnt_n = div_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // Display buffer: idle loads go straight through, otherwise swap at frame wrap.
    always_comb begin
        disp_n    = disp;
        disp_dp_n = disp_dp;
        upd       = 1'b0;
        if (state == IDLE && load) begin
            disp_n    = in_dig;
            disp_dp_n = dp_in;
            upd       = 1'b1;
        end else if (wrap && pend_vld) begin
            disp_n    = pend;
            disp_dp_n = pend_dp;
            upd       = 1'b1;
        end
    end

    always_comb begin
        err_n = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_bad(disp_n[i])) err_n = 1'b1;
    end

    seg_blank_calc #(
        .DIGITS   (DIGITS),
        .LZ_BLANK (LZ_BLANK)
    ) u_blank (
        .disp  (disp_n),
        .blank (blank_n)
    );

    // Outputs are registered from next-state values so they line up with state.
    always_comb begin
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_n == SEL_W'(i)) begin
                cur_bcd   = disp_n[i];
                cur_dp    = disp_dp_n[i];
                cur_blank = blank_n[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            div_cnt    <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            disp       <= '0;
            disp_dp    <= '0;
            sel        <= '0;
            sel_en     <= 1'b0;
            bcd_out    <= '0;
            dp_out     <= 1'b0;
            frame_tick <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            div_cnt    <= cnt_n;
            frame_tick <= tick;
            disp       <= disp_n;
            disp_dp    <= disp_dp_n;
            if (upd) err <= err_n;

            // A load landing on the wrap edge stays pending for the next frame.
            if (load) begin
                pend     <= in_dig;
                pend_dp  <= dp_in;
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end

            case (state_n)
                SHOW: begin
                    sel    <= idx_n;
                    sel_en <= ~cur_blank;
                    dp_out <= cur_dp & ~cur_blank;
                    if (!cur_blank) bcd_out <= cur_bcd;
                end
                GAP: begin
                    sel_en <= 1'b0;
                    dp_out <= 1'b0;
                end
                default: begin
                    sel    <= '0;
                    sel_en <= 1'b0;
                    dp_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
